// File: rtl/int2fp_pkg.sv
// rtl/int2fp_pkg.sv - FP32 constants, rounding modes and round-increment helper
package int2fp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } rm_e;

    // Decide whether the truncated mantissa must be bumped by one ulp
    function automatic logic round_inc(input rm_e rm, input logic sign, input logic lsb,
                                       input logic guard, input logic sticky);
        logic inc;
        case (rm)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign & (guard | sticky);
            RM_RUP:  inc = ~sign & (guard | sticky);
            RM_RMM:  inc = guard;
            default: inc = guard & (sticky | lsb);
        endcase
        return inc;
    endfunction

endpackage

// File: rtl/int2fp_pipe_lzc.sv
// rtl/int2fp_pipe_lzc.sv - combinational leading-zero counter
module lzc #(
    parameter int W = 32
) (
    input  logic [W-1:0]         in_vec,
    output logic [$clog2(W):0]   count,
    output logic                 all_zero
);
    localparam int CW = $clog2(W) + 1;

    // Scan upward so the highest set bit wins; an all-zero vector reports W
    always_comb begin
        count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (in_vec[i]) count = CW'(W - 1 - i);
        end
    end

    assign all_zero = ~|in_vec;

endmodule

// File: rtl/int2fp_pipe.sv
// rtl/int2fp_pipe.sv - 3-stage integer to IEEE-754 single converter with backpressure
module int2fp_pipe
    import int2fp_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_signed,
    input  logic [2:0]       in_rm,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_nx,
    output logic [TAG_W-1:0] out_tag
);
    localparam int LZ_W   = $clog2(IN_W) + 1;
    localparam int FRAC_W = IN_W - 1;
    // Fraction bits below the hidden one, padded so mant/guard/sticky always exist
    localparam int EXT_W  = FRAC_W + MAN_W + 3;
    localparam int BODY_W = EXP_W + MAN_W;

    logic en;
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    // Stage 1 inputs: sign/magnitude split and rounding-mode sanitising
    logic            in_neg;
    logic [IN_W-1:0] in_mag;
    rm_e             in_rm_e;
    assign in_neg  = in_signed & in_data[IN_W-1];
    assign in_mag  = in_neg ? -in_data : in_data;
    assign in_rm_e = (in_rm > 3'd4) ? RM_RNE : rm_e'(in_rm);

    logic             s1_valid, s1_sign;
    logic [IN_W-1:0]  s1_mag;
    rm_e              s1_rm;
    logic [TAG_W-1:0] s1_tag;

    // Stage 1 register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_mag   <= '0;
            s1_rm    <= RM_RNE;
            s1_tag   <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_sign  <= in_neg;
            s1_mag   <= in_mag;
            s1_rm    <= in_rm_e;
            s1_tag   <= in_tag;
        end
    end

    logic [LZ_W-1:0]   s1_lz;
    logic              s1_zero;
    logic [FRAC_W-1:0] s1_frac;

    lzc #(.W(IN_W)) u_lzc (
        .in_vec   (s1_mag),
        .count    (s1_lz),
        .all_zero (s1_zero)
    );

    // The leading one is implicit after normalising, so only the bits below it are kept
    assign s1_frac = FRAC_W'(s1_mag << s1_lz);

    logic              s2_valid, s2_sign, s2_zero;
    logic [FRAC_W-1:0] s2_frac;
    logic [LZ_W-1:0]   s2_lz;
    rm_e               s2_rm;
    logic [TAG_W-1:0]  s2_tag;

    // Stage 2 register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_zero  <= 1'b1;
            s2_frac  <= '0;
            s2_lz    <= '0;
            s2_rm    <= RM_RNE;
            s2_tag   <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_zero  <= s1_zero;
            s2_frac  <= s1_frac;
            s2_lz    <= s1_lz;
            s2_rm    <= s1_rm;
            s2_tag   <= s1_tag;
        end
    end

    logic [EXT_W-1:0]  ext;
    logic [MAN_W-1:0]  mant;
    logic              guard, sticky, inc;
    logic [EXP_W-1:0]  exp_field;
    logic [BODY_W-1:0] body;

    assign ext       = {s2_frac, {(MAN_W + 3){1'b0}}};
    assign mant      = ext[EXT_W-1 -: MAN_W];
    assign guard     = ext[EXT_W-1-MAN_W];
    assign sticky    = |ext[EXT_W-2-MAN_W:0];
    assign exp_field = EXP_W'(BIAS + IN_W - 1) - EXP_W'(s2_lz);
    assign inc       = round_inc(s2_rm, s2_sign, mant[0], guard, sticky);
    // A mantissa carry-out ripples into the exponent field, giving mant = 0, exp + 1
    assign body      = {exp_field, mant} + BODY_W'(inc);

    // Stage 3 (output) register: pack sign/exponent/mantissa, force +0 for zero input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_nx    <= 1'b0;
            out_tag   <= '0;
        end else if (en) begin
            out_valid <= s2_valid;
            out_data  <= s2_zero ? 32'h0000_0000 : {s2_sign, body};
            out_nx    <= ~s2_zero & (guard | sticky);
            out_tag   <= s2_tag;
        end
    end

endmodule

// File: tb/tb_int2fp_pipe.sv
// tb/tb_int2fp_pipe.sv - self-checking bench for int2fp_pipe
module tb_int2fp_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_signed = 1'b0;
    logic [2:0]  in_rm = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_nx;
    logic [4:0]  out_tag;

    logic        w_valid = 1'b0;
    logic [15:0] d16 = '0;
    logic [63:0] d64 = '0;
    logic        s16 = 1'b0, s64 = 1'b0;
    logic [2:0]  rm16 = '0, rm64 = '0;
    logic        r16, v16, nx16, r64, v64, nx64;
    logic [31:0] o16, o64;
    logic [4:0]  t16, t64;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    int2fp_pipe #(.IN_W(32), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_signed(in_signed), .in_rm(in_rm), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_nx(out_nx), .out_tag(out_tag)
    );

    int2fp_pipe #(.IN_W(16), .TAG_W(5)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(w_valid), .in_ready(r16),
        .in_data(d16), .in_signed(s16), .in_rm(rm16), .in_tag(5'd3),
        .out_valid(v16), .out_ready(1'b1), .out_data(o16),
        .out_nx(nx16), .out_tag(t16)
    );

    int2fp_pipe #(.IN_W(64), .TAG_W(5)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(w_valid), .in_ready(r64),
        .in_data(d64), .in_signed(s64), .in_rm(rm64), .in_tag(5'd9),
        .out_valid(v64), .out_ready(1'b1), .out_data(o64),
        .out_nx(nx64), .out_tag(t64)
    );

    // Reference: exact integer arithmetic on the value, rounding by remainder vs half-ulp
    function automatic void ref_conv(input logic [63:0] data_in, input int w, input bit sgn,
                                     input logic [2:0] rm, output logic [31:0] res,
                                     output logic nx);
        logic [63:0] mask, data, mag, q, r, half;
        bit neg, up;
        int e, sh;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        data = data_in & mask;
        neg  = sgn && data[w-1];
        mag  = neg ? ((~data + 64'd1) & mask) : data;
        if (mag == 64'd0) begin
            res = 32'h0;
            nx  = 1'b0;
            return;
        end
        e = 0;
        while ((mag >> (e + 1)) != 64'd0) e++;
        if (e <= 23) begin
            q = mag << (23 - e);
            r = 64'd0;
            half = 64'd1;
        end else begin
            sh = e - 23;
            q = mag >> sh;
            r = mag - (q << sh);
            half = 64'd1 << (sh - 1);
        end
        case (rm)
            3'd1:    up = 1'b0;
            3'd2:    up = neg && (r != 0);
            3'd3:    up = !neg && (r != 0);
            3'd4:    up = (r >= half);
            default: up = (r > half) || ((r == half) && q[0]);
        endcase
        q = q + 64'(up);
        if (q == (64'd1 << 24)) begin
            q = 64'd1 << 23;
            e++;
        end
        res = {neg, 8'(e + 127), q[22:0]};
        nx  = (r != 64'd0);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_nx !== 1'b0 || out_tag !== 5'h0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b d=%h nx=%b t=%h exp all zero",
                     out_valid, out_data, out_nx, out_tag);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic run_one(input logic [31:0] d, input bit s, input logic [2:0] rm,
                           input logic [4:0] tag, input logic [31:0] exp_d,
                           input logic exp_nx, input string name);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = d; in_signed = s; in_rm = rm; in_tag = tag;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s early_valid got=%b exp=0", name, out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_d || out_nx !== exp_nx || out_tag !== tag) begin
            failures++;
            $display("FAIL %s got v=%b d=%h nx=%b t=%h exp v=1 d=%h nx=%b t=%h",
                     name, out_valid, out_data, out_nx, out_tag, exp_d, exp_nx, tag);
        end
    endtask

    task automatic test_directed();
        run_one(32'h7FFF_FFFF, 1, 3'd0, 5'd1, 32'h4F00_0000, 1'b1, "max_rne");
        run_one(32'h7FFF_FFFF, 1, 3'd1, 5'd2, 32'h4EFF_FFFF, 1'b1, "max_rtz");
        run_one(32'h8000_0000, 1, 3'd0, 5'd3, 32'hCF00_0000, 1'b0, "signed_min");
        run_one(32'hFFFF_FFFF, 1, 3'd0, 5'd4, 32'hBF80_0000, 1'b0, "minus_one");
        run_one(32'hFFFF_FFFF, 0, 3'd0, 5'd5, 32'h4F80_0000, 1'b1, "umax_rne");
        run_one(32'h0100_0001, 0, 3'd0, 5'd6, 32'h4B80_0000, 1'b1, "tie_rne");
        run_one(32'h0100_0001, 0, 3'd3, 5'd7, 32'h4B80_0001, 1'b1, "tie_rup");
        run_one(32'h0100_0001, 0, 3'd4, 5'd8, 32'h4B80_0001, 1'b1, "tie_rmm");
        run_one(32'h0100_0001, 1, 3'd7, 5'd9, 32'h4B80_0000, 1'b1, "tie_rm_illegal");
        run_one(32'h0300_0001, 1, 3'd2, 5'd10, 32'h4C40_0000, 1'b1, "rdn_pos");
        for (int m = 0; m < 5; m++)
            run_one(32'h0, 1, 3'(m), 5'(m + 11), 32'h0, 1'b0, "zero");
    endtask

    task automatic test_stream();
        logic [31:0] q_d[$];
        logic        q_nx[$];
        logic [4:0]  q_t[$];
        logic [31:0] ed, hd;
        logic        en_x, hn, acc_in, stalled;
        logic [4:0]  et, ht;
        int issued, got, cyc;
        issued = 0; got = 0; cyc = 0; acc_in = 1'b0; stalled = 1'b0;
        hd = '0; hn = 1'b0; ht = '0;
        while (got < 100 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (!in_valid || acc_in) begin
                if (issued < 100 && $urandom_range(0, 3) != 0) begin
                    in_valid  = 1'b1;
                    in_data   = $urandom >> $urandom_range(0, 31);
                    in_signed = 1'($urandom);
                    in_rm     = 3'($urandom_range(0, 7));
                    in_tag    = 5'($urandom);
                    issued++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== hd || out_nx !== hn || out_tag !== ht) begin
                    failures++;
                    $display("FAIL stall_hold got v=%b d=%h nx=%b t=%h exp v=1 d=%h nx=%b t=%h",
                             out_valid, out_data, out_nx, out_tag, hd, hn, ht);
                end
            end
            if (out_valid && out_ready) begin
                got++;
                checks++;
                if (q_d.size() == 0) begin
                    failures++;
                    $display("FAIL stream_extra got d=%h exp no result", out_data);
                end else begin
                    ed = q_d.pop_front(); en_x = q_nx.pop_front(); et = q_t.pop_front();
                    if (out_data !== ed || out_nx !== en_x || out_tag !== et) begin
                        failures++;
                        $display("FAIL stream_result got d=%h nx=%b t=%h exp d=%h nx=%b t=%h",
                                 out_data, out_nx, out_tag, ed, en_x, et);
                    end
                end
            end
            acc_in = in_valid && in_ready;
            if (acc_in) begin
                ref_conv({32'h0, in_data}, 32, in_signed, in_rm, ed, en_x);
                q_d.push_back(ed); q_nx.push_back(en_x); q_t.push_back(in_tag);
            end
            stalled = out_valid && !out_ready;
            hd = out_data; hn = out_nx; ht = out_tag;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got != 100 || q_d.size() != 0) begin
            failures++;
            $display("FAIL stream_count got=%0d left=%0d exp got=100 left=0", got, q_d.size());
        end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] ed;
        logic        en_x;
        int k;
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 32'h1234_5678 + 32'(i); in_signed = 1'b0;
            in_rm = 3'd0; in_tag = 5'(20 + i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL midstream_inflight got v=%b exp=1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 5'h0) begin
            failures++;
            $display("FAIL async_reset got v=%b d=%h t=%h exp v=0 d=0 t=0", out_valid, out_data, out_tag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) k++;
        end
        checks++;
        if (k != 0) begin
            failures++;
            $display("FAIL stale_results got=%0d exp=0", k);
        end
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_signed = 1'b1; in_rm = 3'd4; in_tag = 5'd30;
        ref_conv({32'h0, 32'hDEAD_BEEF}, 32, 1'b1, 3'd4, ed, en_x);
        k = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid && k == 0) k = i;
        end
        checks++;
        if (k != 3) begin
            failures++;
            $display("FAIL post_reset_latency got=%0d exp=3", k);
        end
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== ed || out_nx !== en_x || out_tag !== 5'd30) begin
            failures++;
            $display("FAIL post_reset_data got v=%b d=%h nx=%b t=%h exp v=1 d=%h nx=%b t=1e",
                     out_valid, out_data, out_nx, out_tag, ed, en_x);
        end
    endtask

    task automatic test_widths();
        logic [31:0] e16, e64;
        logic        n16, n64;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) begin
                d16 = 16'h8000; s16 = 1'b1; rm16 = 3'd0;
                d64 = (64'd1 << 53) + 64'd1; s64 = 1'b1; rm64 = 3'd1;
            end else begin
                d16 = 16'($urandom); s16 = 1'($urandom); rm16 = 3'($urandom_range(0, 4));
                d64 = {32'($urandom), 32'($urandom)} >> $urandom_range(0, 63);
                s64 = 1'($urandom); rm64 = 3'($urandom_range(0, 4));
            end
            ref_conv({48'h0, d16}, 16, s16, rm16, e16, n16);
            ref_conv(d64, 64, s64, rm64, e64, n64);
            if (i == 0) begin
                e16 = 32'hC700_0000; n16 = 1'b0;
                e64 = 32'h5A00_0000; n64 = 1'b1;
            end
            w_valid = 1'b1;
            @(negedge clk);
            w_valid = 1'b0;
            @(negedge clk);
            @(negedge clk);
            checks++;
            if (v16 !== 1'b1 || o16 !== e16 || nx16 !== n16 || t16 !== 5'd3) begin
                failures++;
                $display("FAIL w16 in=%h got v=%b d=%h nx=%b exp d=%h nx=%b", d16, v16, o16, nx16, e16, n16);
            end
            checks++;
            if (v64 !== 1'b1 || o64 !== e64 || nx64 !== n64 || t64 !== 5'd9) begin
                failures++;
                $display("FAIL w64 in=%h got v=%b d=%h nx=%b exp d=%h nx=%b", d64, v64, o64, nx64, e64, n64);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stream();
        test_reset_midstream();
        test_widths();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
